// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-set controller: BCD h/m/s counters advanced by the 1 Hz tick,
// a RUN -> SET_H -> SET_M -> SET_S set-mode FSM, 12/24-hour flag and field-blink controls.

module clock_time_bcd_field #(
    parameter logic [3:0] MAX_T = 4'd5,
    parameter logic [3:0] MAX_U = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       at_max
);
    // at_max feeds the carry chain and the field's own wrap back to 00
    assign at_max = (tens == MAX_T) && (units == MAX_U);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens  <= 4'd0;
                units <= 4'd0;
            end else if (units == 4'd9) begin
                tens  <= tens + 4'd1;
                units <= 4'd0;
            end else begin
                units <= units + 4'd1;
            end
        end
    end
endmodule

module clock_time_ctrl #(
    parameter bit BLINK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_fmt,
    output logic [3:0] bcd_ht,
    output logic [3:0] bcd_hu,
    output logic [3:0] bcd_mt,
    output logic [3:0] bcd_mu,
    output logic [3:0] bcd_st,
    output logic [3:0] bcd_su,
    output logic       day_night,
    output logic       set_active,
    output logic       blank_h,
    output logic       blank_m,
    output logic       blank_s
);
    localparam int NUM_FIELDS = 3; // 0 = seconds, 1 = minutes, 2 = hours

    typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

    state_t state_q, state_d;
    logic   phase_q, phase_d;
    logic   edit_en, run_tick;

    logic [NUM_FIELDS-1:0]      field_inc;
    logic [NUM_FIELDS-1:0]      field_max;
    logic [NUM_FIELDS-1:0][3:0] tens;
    logic [NUM_FIELDS-1:0][3:0] units;

    genvar g;
    generate
        for (g = 0; g < NUM_FIELDS; g++) begin : g_field
            clock_time_bcd_field #(
                .MAX_T((g == 2) ? 4'd2 : 4'd5),
                .MAX_U((g == 2) ? 4'd3 : 4'd9)
            ) u_field (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (field_inc[g]),
                .tens  (tens[g]),
                .units (units[g]),
                .at_max(field_max[g])
            );
        end
    endgenerate

    assign bcd_st = tens[0];
    assign bcd_su = units[0];
    assign bcd_mt = tens[1];
    assign bcd_mu = units[1];
    assign bcd_ht = tens[2];
    assign bcd_hu = units[2];

    // A mode press wins over an edit press landing in the same cycle
    assign edit_en  = key_inc & ~key_mode;
    assign run_tick = (state_q == RUN) & tick_1hz;

    always_comb begin
        field_inc[0] = run_tick | ((state_q == SET_S) & edit_en);
        field_inc[1] = (run_tick & field_max[0]) | ((state_q == SET_M) & edit_en);
        field_inc[2] = (run_tick & field_max[0] & field_max[1]) |
                       ((state_q == SET_H) & edit_en);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (key_mode) state_d = SET_H;
            SET_H:   if (key_mode) state_d = SET_M;
            SET_M:   if (key_mode) state_d = SET_S;
            SET_S:   if (key_mode) state_d = RUN;
            default: state_d = RUN;
        endcase
        // Newly selected field always starts visible
        phase_d = phase_q;
        if (state_d != state_q)
            phase_d = 1'b0;
        else if (tick_1hz && state_q != RUN)
            phase_d = ~phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            phase_q    <= 1'b0;
            day_night  <= 1'b0;
            set_active <= 1'b0;
            blank_h    <= 1'b0;
            blank_m    <= 1'b0;
            blank_s    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            day_night  <= day_night ^ key_fmt;
            set_active <= (state_d != RUN);
            blank_h    <= BLINK_EN && phase_d && (state_d == SET_H);
            blank_m    <= BLINK_EN && phase_d && (state_d == SET_M);
            blank_s    <= BLINK_EN && phase_d && (state_d == SET_S);
        end
    end
endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping and time-set controller for the digital clock.
- Holds the BCD hours/minutes/seconds registers and advances them on the 1 Hz tick.
- Sequences a set-mode FSM (hour -> minute -> second) driven by debounced key pulses.
- Drives the 12/24-hour select flag and field-blink controls consumed by the hour-format conversion and display stages.

Parameters:
- BLINK_EN, 1, when 1 the field being set blanks on alternate 1 Hz ticks; when 0 the blank outputs are tied to 0.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick_1hz  input  1  one-clk-wide pulse, once per second
- key_mode  input  1  one-clk-wide debounced pulse; cycles the set mode
- key_inc  input  1  one-clk-wide debounced pulse; increments the selected field
- key_fmt  input  1  one-clk-wide debounced pulse; toggles 12/24-hour display
- bcd_ht  output  4  hour tens (0-2), 24-hour format
- bcd_hu  output  4  hour units (0-9)
- bcd_mt  output  4  minute tens (0-5)
- bcd_mu  output  4  minute units (0-9)
- bcd_st  output  4  second tens (0-5)
- bcd_su  output  4  second units (0-9)
- day_night  output  1  1 = 12-hour display requested, 0 = 24-hour
- set_active  output  1  1 in any SET state
- blank_h  output  1  blank hour digits (blink)
- blank_m  output  1  blank minute digits (blink)
- blank_s  output  1  blank second digits (blink)

Behaviour:
- All outputs are registered. Every effect is visible on the clk edge after the input pulse (1-cycle latency).
- Reset (async, rst_n=0) sets:
  - time 00:00:00, state RUN, day_night=0, blink_phase=0
  - set_active=0, all blank_*=0
- FSM states: RUN, SET_H, SET_M, SET_S.
  - key_mode transitions: RUN->SET_H->SET_M->SET_S->RUN.
  - set_active=1 in SET_H, SET_M and SET_S.
- RUN:
  - tick_1hz advances time by 1 s with full BCD carry.
  - Second units 9->0 carries to second tens; second tens 5->0 (at :59) carries to minutes.
  - Minutes carry the same way and roll :59 to :00 into hours.
  - Hours roll 23 -> 00. 23:59:59 + tick -> 00:00:00.
  - key_inc is ignored.
- SET states:
  - Time does not advance; tick_1hz only toggles blink_phase.
  - key_inc increments the selected field only, with no carry into the next field:
    - hour 23->00
    - minute 59->00
    - second 59->00
  - BCD units wrap 9->0 and increment the tens digit within the same field.
- blank_h = BLINK_EN & blink_phase & (state==SET_H). blank_m and blank_s are analogous for SET_M and SET_S.
- blink_phase is cleared to 0 on every state transition, so a newly selected field starts visible.
- key_fmt toggles day_night in any state. The time registers are unaffected. The hour outputs are always 24-hour BCD; format conversion happens downstream.
- Simultaneous events:
  - RUN, tick_1hz and key_mode in the same cycle: time advances AND state moves to SET_H.
  - SET_x, key_mode and key_inc in the same cycle: the state advances and the increment is dropped.
  - SET_x, key_inc and tick_1hz in the same cycle: the increment is applied and blink_phase toggles.
  - SET_S -> RUN on key_mode with tick_1hz in the same cycle: the tick is not applied (the state before the edge is SET_S).
  - key_fmt with any other input: the toggle is always applied.
- Reset asserted mid-set returns to RUN at 00:00:00. The partially edited value is discarded.
- Illegal BCD values cannot arise. Any unreachable state encoding recovers to RUN on the next clk.

Test Plan:
- Reset then 3 ticks -> 00:00:03; set_active=0; day_night=0; blank_* all 0.
- Load 23:59:58 via set mode, return to RUN, apply 2 ticks -> 00:00:00 after the second tick; hour rolls 23->00 and tens/units carry correctly at each step.
- key_mode once, key_inc x25 -> state SET_H, hours show 01 (23->00->01); minutes and seconds unchanged. Ticks during SET_H leave seconds frozen and toggle blank_h 0/1.
- In SET_M at minute 59: key_inc -> minute 00, hour unchanged. key_mode+key_inc in the same cycle -> state SET_S, no increment.
- At 12:34:56 in RUN: key_fmt -> day_night=1, time unchanged. key_fmt again -> day_night=0. tick+key_mode together -> 12:34:57 and state SET_H.
- Assert rst_n low asynchronously (not clk-aligned) while in SET_M at 07:45:00 -> outputs 00:00:00, RUN, blank_*=0 immediately. Release and tick -> 00:00:01.
